// File: rtl/seg_scan_mux.sv
// ---------------------------------------------------------------------------
// seg_scan_mux
//
// Time-multiplexed driver for a bank of seven-segment digits. A free-running
// divider gives each digit a slot of DIV clock cycles. At the end of every
// slot the scan index moves to the next enabled digit, skipping disabled
// ones. The selected digit's active-low anode and its active-low segment
// pattern are presented on registered outputs. Digits flagged in ALT_MASK
// take their pattern from seg_b instead of seg_a while sel is high.
//
// Parameters
//   DIGITS    number of multiplexed digits (2..16)
//   DIV       clock cycles per digit slot (2..2^20)
//   ALT_MASK  bit i set: digit i shows seg_b while sel=1
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   scan_en     1 = divider and scan advance, 0 = freeze everything
//   sel         alternate-page select for digits flagged in ALT_MASK
//   seg_a       primary patterns, digit i in bits [7i+6:7i], active low
//   seg_b       alternate patterns, same packing
//   digit_en    per-digit enable, disabled digits are skipped
//   led         registered active-low digit anodes, at most one bit low
//   content     registered active-low segment pattern of the driven digit
//   frame_tick  one-cycle pulse after each slot advance that wraps the scan
//
// Optional feature
//   SEG_SCAN_DEADTIME_EN  when defined, the first max(1, DIV/8) cycles of
//                         every slot are blanked to suppress ghosting.
//                         Slot length and advance timing are unchanged.
// ---------------------------------------------------------------------------
module seg_scan_mux #(
  parameter int                DIGITS   = 8,
  parameter int                DIV      = 50000,
  parameter logic [DIGITS-1:0] ALT_MASK = DIGITS'(8'h0C)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_en,
  input  logic                  sel,
  input  logic [7*DIGITS-1:0]   seg_a,
  input  logic [7*DIGITS-1:0]   seg_b,
  input  logic [DIGITS-1:0]     digit_en,
  output logic [DIGITS-1:0]     led,
  output logic [6:0]            content,
  output logic                  frame_tick
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(DIV);

`ifdef SEG_SCAN_DEADTIME_EN
  localparam int DEAD = ((DIV / 8) < 1) ? 1 : (DIV / 8);
`endif

  logic [CW-1:0]     div_cnt;
  logic [IW-1:0]     idx;
  logic              tick;

  logic [IW-1:0]     next_idx;
  logic              wraps;
  logic [IW-1:0]     up_idx;
  logic [IW-1:0]     low_idx;
  logic              found_up;
  logic              found_low;

  logic              blank;
  logic [DIGITS-1:0] led_next;
  logic [6:0]        content_next;

  // The slot ends in the cycle the divider sits on its last count.
  assign tick = (div_cnt == CW'(DIV - 1));

  // Next-digit search. Scanning from the top down leaves low_idx holding the
  // lowest enabled digit and up_idx holding the lowest enabled digit above
  // the current index. Having no higher candidate means the advance wraps,
  // which also covers the case where the current digit is the only one
  // enabled. With nothing enabled the index holds and nothing wraps.
  always_comb begin
    up_idx    = '0;
    low_idx   = '0;
    found_up  = 1'b0;
    found_low = 1'b0;
    for (int j = DIGITS - 1; j >= 0; j--) begin
      if (digit_en[j]) begin
        low_idx   = IW'(j);
        found_low = 1'b1;
        if (j > int'(idx)) begin
          up_idx   = IW'(j);
          found_up = 1'b1;
        end
      end
    end

    next_idx = idx;
    wraps    = 1'b0;
    if (found_up) begin
      next_idx = up_idx;
    end else if (found_low) begin
      next_idx = low_idx;
      wraps    = 1'b1;
    end
  end

  // Pattern for the digit currently indexed. A digit that has been disabled
  // while it is being shown is blanked until the scan moves past it.
  always_comb begin
    blank = !digit_en[idx];
`ifdef SEG_SCAN_DEADTIME_EN
    if (div_cnt < CW'(DEAD)) begin
      blank = 1'b1;
    end
`endif

    led_next     = '1;
    content_next = 7'h7F;
    if (!blank) begin
      led_next = ~(DIGITS'(1) << idx);
      if (ALT_MASK[idx] && sel) begin
        content_next = seg_b[int'(idx)*7 +: 7];
      end else begin
        content_next = seg_a[int'(idx)*7 +: 7];
      end
    end
  end

  // Divider, scan index and registered outputs. With scan_en low everything
  // holds, except frame_tick, which stays a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      idx        <= '0;
      led        <= '1;
      content    <= 7'h7F;
      frame_tick <= 1'b0;
    end else if (scan_en) begin
      led        <= led_next;
      content    <= content_next;
      frame_tick <= tick && wraps;
      if (tick) begin
        div_cnt <= '0;
        idx     <= next_idx;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end else begin
      frame_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_mux
//
// Scoreboard bench for seg_scan_mux with DIGITS=4, DIV=4, ALT_MASK=4'b1100.
// The driver sets inputs shortly after each falling edge, advances a
// slot-level reference model by one clock and queues the outputs expected
// after the next rising edge. The monitor pops one entry at every falling
// edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_seg_scan_mux;

  localparam int         DIGITS = 4;
  localparam int         DIV    = 4;
  localparam logic [3:0] ALT    = 4'b1100;

`ifdef SEG_SCAN_DEADTIME_EN
  localparam int DEAD = ((DIV / 8) < 1) ? 1 : (DIV / 8);
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic        sel;
  logic [27:0] seg_a;
  logic [27:0] seg_b;
  logic [3:0]  digit_en;
  logic [3:0]  led;
  logic [6:0]  content;
  logic        frame_tick;

  typedef struct {
    logic [3:0] led;
    logic [6:0] content;
    logic       ft;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: position within the slot, digit being shown and
  // the last outputs (held while scanning is frozen).
  int         m_cnt;
  int         m_idx;
  logic [3:0] m_led;
  logic [6:0] m_con;

  seg_scan_mux #(
    .DIGITS   (DIGITS),
    .DIV      (DIV),
    .ALT_MASK (ALT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_en    (scan_en),
    .sel        (sel),
    .seg_a      (seg_a),
    .seg_b      (seg_b),
    .digit_en   (digit_en),
    .led        (led),
    .content    (content),
    .frame_tick (frame_tick)
  );

  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic modelReset();
    m_cnt = 0;
    m_idx = 0;
    m_led = 4'hF;
    m_con = 7'h7F;
  endtask

  // One clock of the reference model, using the inputs currently driven.
  task automatic modelStep(output exp_t e);
    logic [3:0] l;
    logic [6:0] c;
    logic       ft;
    bit         blank;
    bit         found;
    int         j;
    if (rst) begin
      modelReset();
      e = '{4'hF, 7'h7F, 1'b0};
    end else if (!scan_en) begin
      e = '{m_led, m_con, 1'b0};
    end else begin
      l     = 4'hF;
      c     = 7'h7F;
      ft    = 1'b0;
      blank = !digit_en[m_idx];
`ifdef SEG_SCAN_DEADTIME_EN
      if (m_cnt < DEAD) blank = 1'b1;
`endif
      if (!blank) begin
        l[m_idx] = 1'b0;
        c = (ALT[m_idx] && sel) ? seg_b[m_idx*7 +: 7] : seg_a[m_idx*7 +: 7];
      end
      if (m_cnt == DIV - 1 && digit_en != 4'h0) begin
        found = 1'b0;
        for (int k = 1; k <= DIGITS; k++) begin
          j = (m_idx + k) % DIGITS;
          if (!found && digit_en[j]) begin
            found = 1'b1;
            ft    = (j <= m_idx);
            m_idx = j;
          end
        end
      end
      m_cnt = (m_cnt + 1) % DIV;
      m_led = l;
      m_con = c;
      e = '{l, c, ft};
    end
  endtask

  // Drive one clock of stimulus. With pulse set, rst is pulsed between
  // edges first and the outputs are checked while it is asserted.
  task automatic applyStimulus(input logic r, input logic se, input logic sl,
                               input logic [27:0] a, input logic [27:0] b,
                               input logic [3:0] en, input bit pulse);
    exp_t e;
    @(negedge clk);
    #2;
    if (pulse) begin
      rst = 1'b1;
      #1;
      checkOutput("async_rst_led", 32'(led), 32'h0000_000F);
      checkOutput("async_rst_content", 32'(content), 32'h0000_007F);
      checkOutput("async_rst_frame_tick", 32'(frame_tick), 32'h0);
      #1;
      rst = 1'b0;
      modelReset();
    end
    rst      = r;
    scan_en  = se;
    sel      = sl;
    seg_a    = a;
    seg_b    = b;
    digit_en = en;
    modelStep(e);
    exp_q.push_back(e);
  endtask

  // Monitor: compare every presented output with the oldest queued entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("led", 32'(led), 32'(e.led));
        checkOutput("content", 32'(content), 32'(e.content));
        checkOutput("frame_tick", 32'(frame_tick), 32'(e.ft));
      end
    end
  end

  initial begin
    logic [27:0] a;
    logic [27:0] b;
    logic [3:0]  en;
    logic        sl;
    logic        se;
    logic        r;
    bit          p;
    int          base;

    rst      = 1'b1;
    scan_en  = 1'b0;
    sel      = 1'b0;
    seg_a    = '0;
    seg_b    = '0;
    digit_en = 4'h0;
    modelReset();

    $display("[TB] seg_scan_mux scoreboard bench starting");

    base = $urandom_range(0, 127);
    for (int i = 0; i < DIGITS; i++) begin
      a[i*7 +: 7] = 7'((base + i * 17) % 128);
      b[i*7 +: 7] = 7'($urandom_range(0, 127));
    end
    b[2*7 +: 7] = 7'h12;

    // Reset held across several edges.
    for (int n = 0; n < 3; n++) applyStimulus(1'b1, 1'b1, 1'b0, a, b, 4'hF, 1'b0);

    // Full scan of all four digits, primary page.
    for (int n = 0; n < 40; n++) applyStimulus(1'b0, 1'b1, 1'b0, a, b, 4'hF, 1'b0);

    // Flip sel while digit 2 is being shown, then keep it set.
    for (int n = 0; n < 20 && m_led != 4'b1011; n++)
      applyStimulus(1'b0, 1'b1, 1'b0, a, b, 4'hF, 1'b0);
    if (m_led != 4'b1011) checkOutput("reach_digit2", 32'(m_led), 32'hB);
    for (int n = 0; n < 24; n++) applyStimulus(1'b0, 1'b1, 1'b1, a, b, 4'hF, 1'b0);

    // Two enabled digits, then none, then a single one.
    for (int n = 0; n < 24; n++) applyStimulus(1'b0, 1'b1, 1'b0, a, b, 4'b0101, 1'b0);
    for (int n = 0; n < 8; n++)  applyStimulus(1'b0, 1'b1, 1'b0, a, b, 4'b0000, 1'b0);
    for (int n = 0; n < 14; n++) applyStimulus(1'b0, 1'b1, 1'b1, a, b, 4'b0100, 1'b0);

    // Freeze mid-slot for ten cycles and resume.
    for (int n = 0; n < 6; n++)  applyStimulus(1'b0, 1'b1, 1'b0, a, b, 4'hF, 1'b0);
    for (int n = 0; n < 10; n++) applyStimulus(1'b0, 1'b0, 1'b0, a, b, 4'hF, 1'b0);
    for (int n = 0; n < 12; n++) applyStimulus(1'b0, 1'b1, 1'b0, a, b, 4'hF, 1'b0);

    // Asynchronous reset pulse while digit 3 is driven.
    for (int n = 0; n < 20 && m_led != 4'b0111; n++)
      applyStimulus(1'b0, 1'b1, 1'b0, a, b, 4'hF, 1'b0);
    if (m_led != 4'b0111) checkOutput("reach_digit3", 32'(m_led), 32'h7);
    applyStimulus(1'b0, 1'b1, 1'b0, a, b, 4'hF, 1'b1);
    for (int n = 0; n < 20; n++) applyStimulus(1'b0, 1'b1, 1'b0, a, b, 4'hF, 1'b0);

    // Randomized traffic.
    en = 4'hF;
    sl = 1'b0;
    for (int n = 0; n < 400; n++) begin
      se = ($urandom_range(0, 9) != 0);
      r  = ($urandom_range(0, 99) == 0);
      p  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0) sl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        a = 28'($urandom);
        b = 28'($urandom);
      end
      applyStimulus(r, se, sl, a, b, en, p);
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
